// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage: bubble word,
// reset/trap addresses and the fetch state encoding.
package if_fetch_unit_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_HOLD  = 2'd1,
      ST_DRAIN = 2'd2
   } fetch_state_e;

   localparam word_t NOP_WORD    = 32'h2008_0000;  // addi $t0,$zero,0
   localparam word_t RESET_PC    = 32'h0000_0000;
   localparam word_t TRAP_VECTOR = 32'h0000_0080;

   function automatic word_t pc_plus4(word_t pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/ready bus between the fetch stage (master)
// and the instruction memory (slave).
interface if_fetch_unit_if;
   import if_fetch_unit_pkg::*;

   logic  im_req;
   word_t im_addr;
   logic  im_ready;
   word_t im_rdata;

   modport master (output im_req, output im_addr, input im_ready, input im_rdata);
   modport slave  (input im_req, input im_addr, output im_ready, output im_rdata);

endinterface

// File: rtl/if_fetch_unit_pc_next_sel.sv
// Next-PC and effective redirect-target selection for the fetch stage.
// With IF_MISALIGN_TRAP_EN a misaligned target is replaced by TRAP_VECTOR.
module pc_next_sel
   import if_fetch_unit_pkg::*;
(
   input  fetch_state_e state_i,
   input  word_t        pc_i,
   input  word_t        redir_pc_i,
   input  logic         redirect_valid_i,
   input  word_t        redirect_target_i,
   input  logic         im_ready_i,
   input  logic         pc_write_i,
   output word_t        pc_next_o,
   output word_t        eff_target_o,
   output logic         misaligned_o
);

`ifdef IF_MISALIGN_TRAP_EN
   assign misaligned_o = |redirect_target_i[1:0];
   assign eff_target_o = misaligned_o ? TRAP_VECTOR : redirect_target_i;
`else
   assign misaligned_o = 1'b0;
   assign eff_target_o = redirect_target_i & ~32'h0000_0003;
`endif

   always_comb begin
      pc_next_o = pc_i;
      case (state_i)
         ST_FETCH: begin
            // A redirect without data leaves pc on the outstanding request
            // so the drain keeps presenting a stable address.
            if (redirect_valid_i) begin
               if (im_ready_i) pc_next_o = eff_target_o;
            end else if (im_ready_i && pc_write_i) begin
               pc_next_o = pc_plus4(pc_i);
            end
         end
         ST_HOLD: begin
            if (redirect_valid_i)  pc_next_o = eff_target_o;
            else if (pc_write_i)   pc_next_o = pc_plus4(pc_i);
         end
         ST_DRAIN: begin
            if (im_ready_i) pc_next_o = redirect_valid_i ? eff_target_o : redir_pc_i;
         end
         default: pc_next_o = pc_i;
      endcase
   end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, handshakes with a variable-latency
// instruction memory, drops in-flight fetches on redirect and emits NOP
// bubbles when idle. Optional feature macro: IF_MISALIGN_TRAP_EN.
module if_fetch_unit
   import if_fetch_unit_pkg::*;
(
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    pc_write,
   input  logic                    redirect_valid,
   input  word_t                   redirect_target,
   if_fetch_unit_if.master         imem,
   output word_t                   im_out,
   output word_t                   pc_add_out,
   output logic                    fetch_valid,
   output logic                    fetch_fault
);

   fetch_state_e state_q, state_d;
   word_t        pc_q, pc_d;
   word_t        buf_q, buf_d;
   word_t        redir_q, redir_d;
   logic         fault_q, fault_d;

   word_t        eff_target;
   logic         misaligned;
   logic         im_req_c;
   logic         fetch_valid_c;
   word_t        im_out_c;

   pc_next_sel u_pc_next_sel (
      .state_i           (state_q),
      .pc_i              (pc_q),
      .redir_pc_i        (redir_q),
      .redirect_valid_i  (redirect_valid),
      .redirect_target_i (redirect_target),
      .im_ready_i        (imem.im_ready),
      .pc_write_i        (pc_write),
      .pc_next_o         (pc_d),
      .eff_target_o      (eff_target),
      .misaligned_o      (misaligned)
   );

   always_comb begin
      state_d       = state_q;
      buf_d         = buf_q;
      redir_d       = redirect_valid ? eff_target : redir_q;
      fault_d       = fault_q | (redirect_valid & misaligned);
      im_req_c      = 1'b0;
      fetch_valid_c = 1'b0;
      im_out_c      = NOP_WORD;

      case (state_q)
         ST_FETCH: begin
            im_req_c = 1'b1;
            if (redirect_valid) begin
               state_d = imem.im_ready ? ST_FETCH : ST_DRAIN;
            end else if (imem.im_ready) begin
               fetch_valid_c = 1'b1;
               im_out_c      = imem.im_rdata;
               if (!pc_write) begin
                  buf_d   = imem.im_rdata;
                  state_d = ST_HOLD;
               end
            end
         end
         ST_HOLD: begin
            fetch_valid_c = 1'b1;
            im_out_c      = buf_q;
            if (redirect_valid || pc_write) state_d = ST_FETCH;
         end
         ST_DRAIN: begin
            im_req_c = 1'b1;
            if (imem.im_ready) state_d = ST_FETCH;
         end
         default: state_d = ST_FETCH;
      endcase

      // Outputs look like a fresh reset for the whole reset cycle.
      if (reset) begin
         im_req_c      = 1'b0;
         fetch_valid_c = 1'b0;
         im_out_c      = NOP_WORD;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_FETCH;
         pc_q    <= RESET_PC;
         buf_q   <= NOP_WORD;
         redir_q <= RESET_PC;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         buf_q   <= buf_d;
         redir_q <= redir_d;
         fault_q <= fault_d;
      end
   end

   assign imem.im_req  = im_req_c;
   assign imem.im_addr = reset ? RESET_PC : pc_q;
   assign im_out       = im_out_c;
   assign fetch_valid  = fetch_valid_c;
   assign pc_add_out   = reset ? pc_plus4(RESET_PC) : pc_plus4(pc_q);
   assign fetch_fault  = fault_q & ~reset;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed-vector bench for if_fetch_unit: each cycle's stimulus pushes the
// expected outputs into a scoreboard that a negedge monitor pops and checks.
module tb_if_fetch_unit;
   import if_fetch_unit_pkg::*;

   localparam logic [31:0] N = 32'h2008_0000;
`ifdef IF_MISALIGN_TRAP_EN
   localparam logic        M = 1'b1;
   localparam logic [31:0] E = 32'h0000_0080;
`else
   localparam logic        M = 1'b0;
   localparam logic [31:0] E = 32'h0000_0100;
`endif

   typedef struct {
      int          id;
      logic        req;
      logic [31:0] addr;
      logic        fv;
      logic [31:0] out;
      logic [31:0] pa;
      logic        flt;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset;
   logic        pc_write;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic [31:0] im_out, pc_add_out;
   logic        fetch_valid, fetch_fault;

   if_fetch_unit_if imem ();

   int   checks = 0;
   int   errors = 0;
   int   vec_id = 0;
   exp_t sb_q[$];

   if_fetch_unit dut (
      .clock           (clock),
      .reset           (reset),
      .pc_write        (pc_write),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .imem            (imem.master),
      .im_out          (im_out),
      .pc_add_out      (pc_add_out),
      .fetch_valid     (fetch_valid),
      .fetch_fault     (fetch_fault)
   );

   always #5 clock = ~clock;

   task automatic chk(input int id, input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL vec %0d %s: got %h expected %h", id, name, act, exp);
      end
   endtask

   // Monitor: the DUT presents a fresh output word to IF/ID every cycle.
   always @(negedge clock) begin
      if (sb_q.size() > 0) begin
         exp_t e;
         e = sb_q.pop_front();
         chk(e.id, "im_req",      {31'd0, imem.im_req},  {31'd0, e.req});
         chk(e.id, "im_addr",     imem.im_addr,          e.addr);
         chk(e.id, "fetch_valid", {31'd0, fetch_valid},  {31'd0, e.fv});
         chk(e.id, "im_out",      im_out,                e.out);
         chk(e.id, "pc_add_out",  pc_add_out,            e.pa);
         chk(e.id, "fetch_fault", {31'd0, fetch_fault},  {31'd0, e.flt});
         $display("vec %0d req=%0b addr=%h fv=%0b out=%h pa=%h flt=%0b", e.id,
                  imem.im_req, imem.im_addr, fetch_valid, im_out, pc_add_out, fetch_fault);
      end
   end

   task automatic step(input logic rst, input logic pcw, input logic rv, input logic [31:0] rt,
                       input logic rdy, input logic [31:0] rd,
                       input logic e_req, input logic [31:0] e_addr, input logic e_fv,
                       input logic [31:0] e_out, input logic [31:0] e_pa, input logic e_flt);
      exp_t e;
      @(posedge clock);
      #1;
      reset           = rst;
      pc_write        = pcw;
      redirect_valid  = rv;
      redirect_target = rt;
      imem.im_ready   = rdy;
      imem.im_rdata   = rd;
      vec_id++;
      e.id = vec_id; e.req = e_req; e.addr = e_addr; e.fv = e_fv;
      e.out = e_out; e.pa = e_pa; e.flt = e_flt;
      sb_q.push_back(e);
   endtask

   initial begin
      reset = 1'b1; pc_write = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
      imem.im_ready = 1'b0; imem.im_rdata = '0;

      //    rst pcw rv target        rdy rdata          req addr           fv out            pa             flt
      step(1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,        0, N,            32'h4,        0);
      step(1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,        0, N,            32'h4,        0);
      // zero-wait streaming
      step(0, 1, 0, 32'h0,         1, 32'h2001_0001, 1, 32'h0,        1, 32'h2001_0001, 32'h4,       0);
      step(0, 1, 0, 32'h0,         1, 32'h2001_0002, 1, 32'h4,        1, 32'h2001_0002, 32'h8,       0);
      step(0, 1, 0, 32'h0,         1, 32'h2001_0003, 1, 32'h8,        1, 32'h2001_0003, 32'hC,       0);
      // stall: HOLD keeps the word, no request
      step(0, 0, 0, 32'h0,         1, 32'h8C01_0004, 1, 32'hC,        1, 32'h8C01_0004, 32'h10,      0);
      step(0, 0, 0, 32'h0,         0, 32'h0,         0, 32'hC,        1, 32'h8C01_0004, 32'h10,      0);
      step(0, 0, 0, 32'h0,         0, 32'h0,         0, 32'hC,        1, 32'h8C01_0004, 32'h10,      0);
      step(0, 1, 0, 32'h0,         0, 32'h0,         0, 32'hC,        1, 32'h8C01_0004, 32'h10,      0);
      // latency-3 fetch redirected one cycle after request
      step(0, 1, 0, 32'h0,         0, 32'h0,         1, 32'h10,       0, N,            32'h14,       0);
      step(0, 1, 1, 32'h40,        0, 32'h0,         1, 32'h10,       0, N,            32'h14,       0);
      step(0, 1, 0, 32'h0,         0, 32'h0,         1, 32'h10,       0, N,            32'h14,       0);
      step(0, 1, 0, 32'h0,         1, 32'hDEAD_BEEF, 1, 32'h10,       0, N,            32'h14,       0);
      step(0, 1, 0, 32'h0,         0, 32'h0,         1, 32'h40,       0, N,            32'h44,       0);
      // redirect coincides with im_ready
      step(0, 1, 1, 32'h100,       1, 32'h1234_5678, 1, 32'h40,       0, N,            32'h44,       0);
      step(0, 1, 0, 32'h0,         0, 32'h0,         1, 32'h100,      0, N,            32'h104,      0);
      // misaligned redirect through a drain
      step(0, 1, 1, 32'h102,       0, 32'h0,         1, 32'h100,      0, N,            32'h104,      0);
      step(0, 1, 0, 32'h0,         1, 32'h5555_5555, 1, 32'h100,      0, N,            32'h104,      M);
      step(0, 1, 0, 32'h0,         0, 32'h0,         1, E,            0, N,            E + 32'h4,    M);
      // back-to-back redirects during a drain: latest wins
      step(0, 1, 1, 32'h200,       0, 32'h0,         1, E,            0, N,            E + 32'h4,    M);
      step(0, 1, 1, 32'h300,       0, 32'h0,         1, E,            0, N,            E + 32'h4,    M);
      step(0, 1, 0, 32'h0,         1, 32'h7777_7777, 1, E,            0, N,            E + 32'h4,    M);
      step(0, 1, 0, 32'h0,         0, 32'h0,         1, 32'h300,      0, N,            32'h304,      M);
      // PC wrap at the top of the address space
      step(0, 1, 1, 32'hFFFF_FFFC, 1, 32'h8888_8888, 1, 32'h300,      0, N,            32'h304,      M);
      step(0, 1, 0, 32'h0,         1, 32'hB000_0000, 1, 32'hFFFF_FFFC, 1, 32'hB000_0000, 32'h0,      M);
      step(0, 1, 0, 32'h0,         1, 32'hB000_0001, 1, 32'h0,        1, 32'hB000_0001, 32'h4,       M);
      // redirect out of HOLD drops the held word
      step(0, 0, 0, 32'h0,         1, 32'hB000_0002, 1, 32'h4,        1, 32'hB000_0002, 32'h8,       M);
      step(0, 0, 1, 32'h500,       0, 32'h0,         0, 32'h4,        1, 32'hB000_0002, 32'h8,       M);
      step(0, 1, 0, 32'h0,         0, 32'h0,         1, 32'h500,      0, N,            32'h504,      M);
      // reset while draining
      step(0, 1, 1, 32'h600,       0, 32'h0,         1, 32'h500,      0, N,            32'h504,      M);
      step(1, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0,        0, N,            32'h4,        0);
      step(0, 1, 0, 32'h0,         0, 32'h0,         1, 32'h0,        0, N,            32'h4,        0);
      step(0, 1, 0, 32'h0,         1, 32'hC000_0000, 1, 32'h0,        1, 32'hC000_0000, 32'h4,       0);

      begin
         int budget = 10;
         while (sb_q.size() > 0 && budget > 0) begin
            @(posedge clock);
            budget--;
         end
      end
      if (sb_q.size() > 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage feeding the IF/ID pipeline register. It owns the PC, runs a request/ready handshake with an instruction memory of variable latency, and delivers one instruction plus its PC+4 per cycle. A redirect from branch/jump resolution drops any in-flight fetch. When no instruction is available, the block presents a NOP bubble so IF/ID can capture every cycle.

## Interface
- RESET_PC, 32'h0000_0000, PC fetched first after reset
- NOP, 32'h2008_0000, bubble word (addi $t0,$zero,0) driven when no valid instruction
- TRAP_VECTOR, 32'h0000_0080, redirect target for misaligned redirects (used only with macro)
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- pc_write  in  1  IF_ID_Write from hazard unit; 1 = downstream consumes im_out this cycle
- redirect_valid  in  1  branch/jump taken; redirect_target is valid
- redirect_target  in  32  new fetch address
- im_req  out  1  fetch request to instruction memory
- im_addr  out  32  fetch address; stable while im_req high until im_ready
- im_ready  in  1  one-cycle pulse, im_rdata valid
- im_rdata  in  32  fetched instruction word
- im_out  out  32  instruction to IF/ID (NOP when fetch_valid=0)
- pc_add_out  out  32  PC+4 of the instruction on im_out
- fetch_valid  out  1  im_out holds a real instruction
- fetch_fault  out  1  sticky misaligned-redirect flag (tied 0 without macro)

## Operation
- State: pc (32), buf_instr (32), redir_pc (32), state ∈ {FETCH, HOLD, DRAIN}.
- FETCH: im_req=1, im_addr=pc. Priority: redirect > im_ready.
  - redirect_valid & im_ready: discard data, pc←target, stay FETCH.
  - redirect_valid & !im_ready: redir_pc←target, go DRAIN.
  - im_ready & pc_write: bypass im_rdata to im_out (fetch_valid=1), pc←pc+4, stay FETCH.
  - im_ready & !pc_write: buf_instr←im_rdata, go HOLD.
- HOLD: im_req=0, im_out=buf_instr, fetch_valid=1. redirect_valid: pc←target, go FETCH (held word dropped). Else pc_write: pc←pc+4, go FETCH. Else stay.
- DRAIN: im_req=1 on the old pc until im_ready. Returned data is discarded. A new redirect overwrites redir_pc (latest wins). On im_ready: pc←redir_pc, go FETCH. fetch_valid=0.
- pc_add_out = pc+4 at all times, mod 2^32 (wraps 32'hFFFF_FFFC→0).
- Without redirect, fetch_valid=0 ⇒ im_out=NOP.

## Timing
- Reset (any state, including DRAIN with a fetch outstanding): pc=RESET_PC, state=FETCH, im_req=0 during the reset cycle, fetch_valid=0, im_out=NOP, pc_add_out=RESET_PC+4, fetch_fault=0. Any im_ready arriving after reset for a pre-reset request is the integrator's responsibility; memory is reset together with this block.
- First im_req occurs in the cycle after reset deasserts.
- Zero-wait memory (im_ready in the same cycle as im_req): 1 instruction/cycle, combinational im_rdata→im_out path.
- Latency of N cycles: instruction visible in the cycle im_ready rises.
- Redirect takes effect on the next edge. The first target instruction is requested the next cycle (or after the drain completes).

## Configuration
- IF_MISALIGN_TRAP_EN defined: redirect_target[1:0]≠0 ⇒ effective target=TRAP_VECTOR, and fetch_fault is set (sticky until reset).
- Not defined: target low 2 bits are forced to 00, and fetch_fault is constant 0.

## Structure
- Shared package: NOP word, fetch state encoding (FETCH/HOLD/DRAIN), 32-bit word typedef.
- One sub-module `pc_next_sel`: combinational next-PC/effective-target selection, including the misalign check under the macro.

## Test plan
- Reset with RESET_PC=0 and zero-wait memory, pc_write=1 -> im_addr 0,4,8 on consecutive cycles; pc_add_out 4,8,12; fetch_valid=1 each cycle.
- pc_write=0 for 3 cycles after im_ready of word 32'h8C010004 -> HOLD, im_req=0, im_out stays 32'h8C010004; resume -> im_addr=pc+4.
- Memory latency 3, redirect to 0x40 one cycle after request -> DRAIN, old data discarded, fetch_valid=0 throughout, next im_addr=0x40.
- Redirect and im_ready in the same cycle (target 0x100) -> data dropped, next im_addr=0x100, im_out=NOP.
- Macro on, redirect to 0x102 -> next im_addr=TRAP_VECTOR 0x80, fetch_fault=1 held until reset. Macro off, same stimulus -> im_addr=0x100, fetch_fault=0.
- pc=32'hFFFF_FFFC advance -> pc_add_out=0, next im_addr=0.
